// File: rtl/shift_add_multiplier_4bit.sv
// Sequential 4x4 unsigned add-shift multiplier driving a 4-bit ripple adder.
// Optional build macro: MUL_ZERO_SKIP_EN (zero operand finishes in one cycle).

module rippleadder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < 4; i++) begin
            sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[4];
    end
endmodule

module shift_add_multiplier_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Product,
    output logic [1:0]           state_dbg_o
);
    // Handshake: start is sampled on a rising edge only in IDLE or DONE;
    // busy marks the ADD cycles, done is a one-cycle pulse and Product holds
    // its value from done until the next accepted start.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [1:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    assign add_b = q_q[0] ? m_q : '0;

    rippleadder_4bit u_adder (
        .a_i    (acc_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ADD;
`ifdef MUL_ZERO_SKIP_EN
                    if (A == '0 || B == '0) begin
                        q_d     = '0;
                        state_d = S_DONE;
                    end
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                // 9-bit {Cout,Sum,Q} shifted right by one into {acc,Q}
                {acc_d, q_d} = {add_cout, add_sum, q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = (state_q == S_ADD);
    assign done        = (state_q == S_DONE);
    assign Product     = {acc_q, q_q};
    assign state_dbg_o = state_q;
endmodule

// File: tb/tb_shift_add_multiplier_4bit.sv
// Self-checking bench for shift_add_multiplier_4bit: latency, handshake,
// reset abort and an exhaustive back-to-back sweep against a product queue.

module tb_shift_add_multiplier_4bit;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [1:0] state_dbg;

    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    int n_cmp = 0;
    int n_err = 0;

`ifdef MUL_ZERO_SKIP_EN
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = 5;
    localparam int ZBUSY = 4;
`endif

    shift_add_multiplier_4bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (a),
        .B           (b),
        .busy        (busy),
        .done        (done),
        .Product     (product),
        .state_dbg_o (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver: one-cycle start pulse, expected product pushed to the scoreboard
    task automatic drive_start(input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        exp_q.push_back(8'(av) * 8'(bv));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // counts sampled cycles after the start edge until done (-1 on timeout)
    task automatic wait_done(output int cyc, output int busy_n);
        cyc    = -1;
        busy_n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic pop_exp(output logic [7:0] v);
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: done with empty expected queue");
            v = 8'hxx;
        end else begin
            v = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, product, state_dbg} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b product=%h state=%0d required all zero",
                     busy, done, product, state_dbg);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [3:0] av[3] = '{4'hF, 4'h3, 4'h8};
        logic [3:0] bv[3] = '{4'hF, 4'h5, 4'h2};
        logic [7:0] lit[3] = '{8'hE1, 8'h0F, 8'h10};
        int cyc, bn;
        for (int i = 0; i < 3; i++) begin
            drive_start(av[i], bv[i]);
            wait_done(cyc, bn);
            pop_exp(exp_v);
            n_cmp++;
            if (cyc !== 5 || bn !== 4) begin
                n_err++;
                $display("FAIL basic_latency[%0d]: done at %0d busy %0d cycles, required 5 and 4", i, cyc, bn);
            end
            n_cmp++;
            if (product !== exp_v || product !== lit[i]) begin
                n_err++;
                $display("FAIL basic_product[%0d]: got %h required %h", i, product, lit[i]);
            end
        end
        // product must hold after done until the next start
        repeat (3) @(negedge clk);
        n_cmp++;
        if (product !== 8'h10 || done !== 1'b0) begin
            n_err++;
            $display("FAIL product_hold: got %h done=%b required 10 done=0", product, done);
        end
    endtask

    task automatic test_zero();
        int cyc, bn;
        drive_start(4'h0, 4'h9);
        wait_done(cyc, bn);
        pop_exp(exp_v);
        n_cmp++;
        if (cyc !== ZLAT || bn !== ZBUSY) begin
            n_err++;
            $display("FAIL zero_latency: done at %0d busy %0d, required %0d and %0d", cyc, bn, ZLAT, ZBUSY);
        end
        n_cmp++;
        if (product !== exp_v) begin
            n_err++;
            $display("FAIL zero_product: got %h required %h", product, exp_v);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_one_cycle: done=%b required 0", done);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc, bn;
        @(negedge clk);
        a     = 4'h7;
        b     = 4'h6;
        start = 1'b1;
        exp_q.push_back(8'h2A);
        @(posedge clk);
        #1;
        a = 4'h1;
        b = 4'h1;
        wait_done(cyc, bn);
        pop_exp(exp_v);
        n_cmp++;
        if (cyc !== 5 || bn !== 4) begin
            n_err++;
            $display("FAIL busy_ignore_latency: done at %0d busy %0d, required 5 and 4", cyc, bn);
        end
        n_cmp++;
        if (product !== exp_v) begin
            n_err++;
            $display("FAIL busy_ignore_product: got %h required %h", product, exp_v);
        end
        // start still high in the done cycle: accepted on the next edge
        exp_q.push_back(8'h01);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc, bn);
        pop_exp(exp_v);
        n_cmp++;
        if (cyc !== 5) begin
            n_err++;
            $display("FAIL chained_latency: done at %0d required 5", cyc);
        end
        n_cmp++;
        if (product !== exp_v) begin
            n_err++;
            $display("FAIL chained_product: got %h required %h", product, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bn, exp_lat;
        logic [3:0] ca, cb;
        ca = 4'h0;
        cb = 4'h0;
        drive_start(4'h0, 4'h0);
        for (int n = 0; n < 256; n++) begin
            exp_lat = (ca == 0 || cb == 0) ? ZLAT : 5;
            wait_done(cyc, bn);
            pop_exp(exp_v);
            n_cmp++;
            if (cyc !== exp_lat) begin
                n_err++;
                $display("FAIL sweep_latency %h*%h: done at %0d required %0d", ca, cb, cyc, exp_lat);
            end
            n_cmp++;
            if (product !== exp_v) begin
                n_err++;
                $display("FAIL sweep_product %h*%h: got %h required %h", ca, cb, product, exp_v);
            end
            if (cyc < 0) break;
            if (n < 255) begin
                ca    = 4'((n + 1) / 16);
                cb    = 4'((n + 1) % 16);
                a     = ca;
                b     = cb;
                start = 1'b1;
                exp_q.push_back(8'(ca) * 8'(cb));
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bn, done_seen;
        drive_start(4'hF, 4'hF);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            n_err++;
            $display("FAIL reset_abort: busy=%b done=%b product=%h required 0 0 00", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a     = $urandom_range(1, 15);
        b     = $urandom_range(1, 15);
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        n_cmp++;
        if (done_seen !== 0) begin
            n_err++;
            $display("FAIL reset_quiet: %0d active cycles after release, required 0", done_seen);
        end
        for (int i = 0; i < 4; i++) begin
            drive_start(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_done(cyc, bn);
            pop_exp(exp_v);
            n_cmp++;
            if (product !== exp_v || cyc < 0) begin
                n_err++;
                $display("FAIL post_reset_product[%0d]: got %h required %h (done at %0d)", i, product, exp_v, cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
